// File: rtl/div_share_arb_pkg.sv
// Shared types and helpers for the divider-sharing arbiter.
// State encoding is fixed so the FSM can be decoded from a waveform by its raw value.
package div_share_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 64;

  // Next requester index after idx, wrapping at n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_arb_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    grant,
  output logic             any_valid
);

  // Scan from the farthest offset back to ptr so the closest match wins last.
  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[IW'(idx)]) begin
        grant     = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_arb.sv
// Round-robin sequencer sharing one req/ack divider among N_REQ requesters,
// with divide-by-zero bypass and a timeout for a divider that never answers.
module div_share_arb
  import div_share_arb_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = $clog2(N_REQ),
  localparam int DW      = 2 * WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_req,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       data_ack,
  output logic                err,
  output logic                busy,
  output logic [IW-1:0]       grant_id,
  output logic                div_req,
  output logic [DW-1:0]       div_data_req,
  input  logic                div_ack,
  input  logic [DW-1:0]       div_data_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [IW-1:0]     ptr;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     pick;
  logic              any_valid;
  logic [DW-1:0]     pick_data;
  logic [WIDTH-1:0]  pick_a, pick_b;
  logic [N_REQ-1:0]  pick_onehot, grant_onehot;
  logic              expire;

  rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) pick_data = data_req[i*DW +: DW];
    end
    pick_a       = pick_data[DW-1:WIDTH];
    pick_b       = pick_data[WIDTH-1:0];
    pick_onehot  = N_REQ'(1) << pick;
    grant_onehot = N_REQ'(1) << grant_id;
    // Timer holds cycles already spent in WAIT, so this is the TIMEOUT-th cycle.
    expire       = (timer == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_valid) state_next = (pick_b == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (div_ack || expire) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ack and div_req are single-cycle pulses; results and operands hold until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack          <= '0;
      data_ack     <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      div_req      <= 1'b0;
      div_data_req <= '0;
      ptr          <= '0;
      timer        <= '0;
    end else begin
      busy    <= (state_next != S_IDLE);
      ack     <= '0;
      div_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            if (pick_b == '0) begin
              data_ack <= {pick_a, {WIDTH{1'b1}}};
              err      <= 1'b1;
              ack      <= pick_onehot;
            end else begin
              div_req      <= 1'b1;
              div_data_req <= pick_data;
            end
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (div_ack) begin
            data_ack <= div_data_ack;
            err      <= 1'b0;
            ack      <= grant_onehot;
          end else if (expire) begin
            data_ack <= '0;
            err      <= 1'b1;
            ack      <= grant_onehot;
          end
        end
        S_RESP: ptr <= IW'(wrap_inc(int'(grant_id), N_REQ));
        default: ;
      endcase
    end
  end

endmodule
